// File: rtl/bus_sequencer.sv
// Control-step sequencer for the single-bus datapath: instruction fetch plus the
// register/immediate ALU subset. At most one bus driver is selected per cycle.
module bus_sequencer #(
  parameter bit WAIT_FOR_MEM = 1'b1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic        hi_out,
  output logic        lo_out,
  output logic        zhi_out,
  output logic        zlo_out,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        inport_out,
  output logic        c_out,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        mem_read,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  step
);

  // state  | meaning
  // S_T0   | PC to MAR, Z <= PC+1
  // S_T1   | memory read, wait for mem_ready, PC <= Z on exit
  // S_T2   | IR <= MDR
  // S_T3   | decode; first operand into Y
  // S_T4   | ALU operation, second operand, Z <= result
  // S_T5   | Z low to Ra (reg ops) or LO (mul/div)
  // S_T6   | Z high to HI (mul/div only)
  // S_HALT | stopped until reset
  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  w_opcode;
  logic [15:0] w_sel_ra, w_sel_rb, w_sel_rc;
  logic        w_is_reg, w_is_addi, w_is_md, w_is_alu, w_mem_done;
  logic        w_unused;

  assign w_opcode   = ir[31:27];
  assign w_sel_ra   = 16'd1 << ir[26:23];
  assign w_sel_rb   = 16'd1 << ir[22:19];
  assign w_sel_rc   = 16'd1 << ir[18:15];
  assign w_is_reg   = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                      (w_opcode == OP_AND) || (w_opcode == OP_OR);
  assign w_is_addi  = (w_opcode == OP_ADDI);
  assign w_is_md    = (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
  assign w_is_alu   = w_is_reg || w_is_addi || w_is_md;
  assign w_mem_done = !WAIT_FOR_MEM || mem_ready;
  assign w_unused   = ^ir[14:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_T0;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    reg_out    = '0;
    reg_in     = '0;
    hi_out     = 1'b0;
    lo_out     = 1'b0;
    zhi_out    = 1'b0;
    zlo_out    = 1'b0;
    pc_out     = 1'b0;
    mdr_out    = 1'b0;
    inport_out = 1'b0;
    c_out      = 1'b0;
    pc_in      = 1'b0;
    ir_in      = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    hi_in      = 1'b0;
    lo_in      = 1'b0;
    inc_pc     = 1'b0;
    mem_read   = 1'b0;
    alu_op     = '0;
    halted     = 1'b0;
    illegal    = 1'b0;
    step       = r_state;
    case (r_state)
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        // pc_in only on the exit cycle so a stalled fetch loads PC once
        zlo_out = 1'b1; mem_read = 1'b1; mdr_in = 1'b1;
        if (w_mem_done) begin
          pc_in  = 1'b1;
          w_next = S_T2;
        end
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
        w_next  = S_T3;
      end
      S_T3: begin
        if (w_is_alu) begin
          reg_out = w_is_md ? w_sel_ra : w_sel_rb;
          y_in    = 1'b1;
          w_next  = S_T4;
        end else if (w_opcode == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          illegal = (w_opcode != OP_NOP);
          w_next  = S_T0;
        end
      end
      S_T4: begin
        alu_op = w_opcode;
        z_in   = 1'b1;
        if (w_is_reg)  reg_out = w_sel_rc;
        if (w_is_addi) c_out   = 1'b1;
        if (w_is_md)   reg_out = w_sel_rb;
        w_next = S_T5;
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (w_is_md) begin
          lo_in  = 1'b1;
          w_next = S_T6;
        end else begin
          if (w_is_alu) reg_in = w_sel_ra;
          w_next = S_T0;
        end
      end
      S_T6: begin
        zhi_out = 1'b1; hi_in = 1'b1;
        w_next  = S_T0;
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_T0;
    endcase
    // strobes must drop the instant clear falls, not at the next edge
    if (!clear) begin
      reg_out = '0; reg_in = '0;
      hi_out = 1'b0; lo_out = 1'b0; zhi_out = 1'b0; zlo_out = 1'b0;
      pc_out = 1'b0; mdr_out = 1'b0; inport_out = 1'b0; c_out = 1'b0;
      pc_in = 1'b0; ir_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
      y_in = 1'b0; z_in = 1'b0; hi_in = 1'b0; lo_in = 1'b0;
      inc_pc = 1'b0; mem_read = 1'b0;
      alu_op = '0; halted = 1'b0; illegal = 1'b0; step = '0;
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed vector table, hand-written
// corner sequences, and a random instruction stream against a per-instruction model.
module tb_bus_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] reg_out, reg_in;
  logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
  logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read;
  logic [4:0]  alu_op;
  logic        halted, illegal;
  logic [2:0]  step;

  bus_sequencer #(.WAIT_FOR_MEM(1'b1)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .reg_out(reg_out), .reg_in(reg_in),
    .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
    .pc_out(pc_out), .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
    .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
    .inc_pc(inc_pc), .mem_read(mem_read),
    .alu_op(alu_op), .halted(halted), .illegal(illegal), .step(step)
  );

  always #5 clock = ~clock;

  localparam logic [17:0] HI_OUT  = 18'h20000, LO_OUT  = 18'h10000;
  localparam logic [17:0] ZHI_OUT = 18'h08000, ZLO_OUT = 18'h04000;
  localparam logic [17:0] PC_OUT  = 18'h02000, MDR_OUT = 18'h01000;
  localparam logic [17:0] C_OUT   = 18'h00400, PC_IN   = 18'h00200;
  localparam logic [17:0] IR_IN   = 18'h00100, MAR_IN  = 18'h00080;
  localparam logic [17:0] MDR_IN  = 18'h00040, Y_IN    = 18'h00020;
  localparam logic [17:0] Z_IN    = 18'h00010, HI_IN   = 18'h00008;
  localparam logic [17:0] LO_IN   = 18'h00004, INC_PC  = 18'h00002;
  localparam logic [17:0] MEM_READ = 18'h00001;

  localparam logic [31:0] IR_ADD  = 32'h1989_0000; // add  R3,R1,R2
  localparam logic [31:0] IR_ADDI = 32'h67B8_0000; // addi R15,R7
  localparam logic [31:0] IR_MUL  = 32'h7928_0000; // mul  R2,R5
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  typedef struct packed {
    logic [15:0] ro;
    logic [15:0] ri;
    logic [17:0] s;
    logic [4:0]  op;
    logic        halted;
    logic        illegal;
    logic [2:0]  step;
  } outs_t;

  typedef struct {
    logic [31:0] ir;
    logic        mr;
    outs_t       exp;
  } vec_t;

  int checks = 0, failures = 0, cyc = 0;
  int t1_cnt = 0, ill_cnt = 0, ri_cnt = 0;
  vec_t q[$];

  function automatic outs_t mk(logic [2:0] st, logic [17:0] s, logic [15:0] ro,
                               logic [15:0] ri, logic [4:0] op, logic h, logic il);
    outs_t o;
    o.ro = ro; o.ri = ri; o.s = s; o.op = op; o.halted = h; o.illegal = il; o.step = st;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.ro = reg_out; o.ri = reg_in;
    o.s = {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out,
           pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read};
    o.op = alu_op; o.halted = halted; o.illegal = illegal; o.step = step;
    return o;
  endfunction

  task automatic check_out(string nm, outs_t exp);
    outs_t act = sample();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_eq(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs and invariants, advance to just after the next edge.
  task automatic apply(vec_t v, string nm);
    ir = v.ir;
    mem_ready = v.mr;
    #1;
    check_out(nm, v.exp);
    check_eq("bus_onehot", int'($countones({reg_out, hi_out, lo_out, zhi_out, zlo_out,
             pc_out, mdr_out, inport_out, c_out}) <= 1), 1);
    check_eq("alu_op_only_t4", int'(alu_op == 5'd0 || step == 3'd4), 1);
    if (step == 3'd1) t1_cnt++;
    if (illegal) ill_cnt++;
    if (reg_in != 16'd0) ri_cnt++;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic void push(logic [31:0] i, logic m, outs_t e);
    vec_t v;
    v.ir = i; v.mr = m; v.exp = e;
    q.push_back(v);
  endfunction

  // Expected cycle list of one instruction; ir is junk until decode, ignored by the DUT.
  function automatic void build(logic [31:0] irv, int nwait);
    logic [4:0]  op = irv[31:27];
    logic [15:0] a = 16'd1 << irv[26:23];
    logic [15:0] b = 16'd1 << irv[22:19];
    logic [15:0] c = 16'd1 << irv[18:15];
    bit md  = (op == 5'd15) || (op == 5'd16);
    bit rr  = (op >= 5'd3) && (op <= 5'd6);
    bit imm = (op == 5'd12);
    q.delete();
    push($urandom, 1'($urandom), mk(0, PC_OUT | MAR_IN | INC_PC | Z_IN, 0, 0, 0, 0, 0));
    for (int w = 0; w < nwait; w++)
      push($urandom, 1'b0, mk(1, ZLO_OUT | MEM_READ | MDR_IN, 0, 0, 0, 0, 0));
    push($urandom, 1'b1, mk(1, ZLO_OUT | MEM_READ | MDR_IN | PC_IN, 0, 0, 0, 0, 0));
    push($urandom, 1'($urandom), mk(2, MDR_OUT | IR_IN, 0, 0, 0, 0, 0));
    if (md || rr || imm) begin
      push(irv, 1'($urandom), mk(3, Y_IN, md ? a : b, 0, 0, 0, 0));
      push(irv, 1'($urandom), mk(4, Z_IN | (imm ? C_OUT : 18'd0),
                                 rr ? c : (md ? b : 16'd0), 0, op, 0, 0));
      if (md) begin
        push(irv, 1'($urandom), mk(5, ZLO_OUT | LO_IN, 0, 0, 0, 0, 0));
        push(irv, 1'($urandom), mk(6, ZHI_OUT | HI_IN, 0, 0, 0, 0, 0));
      end else begin
        push(irv, 1'($urandom), mk(5, ZLO_OUT, 0, a, 0, 0, 0));
      end
    end else begin
      push(irv, 1'($urandom), mk(3, 0, 0, 0, 0, 0, (op != 5'd26 && op != 5'd27)));
    end
  endfunction

  task automatic run_q(string nm, int n);
    for (int i = 0; i < n && i < q.size(); i++) apply(q[i], nm);
  endtask

  vec_t tbl[12];
  logic [4:0] legal_ops[8] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd15, 5'd16, 5'd26};

  initial begin
    tbl[0]  = '{IR_ADD, 1'b1, mk(0, PC_OUT | MAR_IN | INC_PC | Z_IN, 0, 0, 0, 0, 0)};
    tbl[1]  = '{IR_ADD, 1'b1, mk(1, ZLO_OUT | PC_IN | MEM_READ | MDR_IN, 0, 0, 0, 0, 0)};
    tbl[2]  = '{IR_ADD, 1'b1, mk(2, MDR_OUT | IR_IN, 0, 0, 0, 0, 0)};
    tbl[3]  = '{IR_ADD, 1'b1, mk(3, Y_IN, 16'h0002, 0, 0, 0, 0)};
    tbl[4]  = '{IR_ADD, 1'b1, mk(4, Z_IN, 16'h0004, 0, 5'b00011, 0, 0)};
    tbl[5]  = '{IR_ADD, 1'b1, mk(5, ZLO_OUT, 0, 16'h0008, 0, 0, 0)};
    tbl[6]  = '{IR_ADDI, 1'b1, mk(0, PC_OUT | MAR_IN | INC_PC | Z_IN, 0, 0, 0, 0, 0)};
    tbl[7]  = '{IR_ADDI, 1'b1, mk(1, ZLO_OUT | PC_IN | MEM_READ | MDR_IN, 0, 0, 0, 0, 0)};
    tbl[8]  = '{IR_ADDI, 1'b0, mk(2, MDR_OUT | IR_IN, 0, 0, 0, 0, 0)};
    tbl[9]  = '{IR_ADDI, 1'b0, mk(3, Y_IN, 16'h0080, 0, 0, 0, 0)};
    tbl[10] = '{IR_ADDI, 1'b0, mk(4, Z_IN | C_OUT, 0, 0, 5'b01100, 0, 0)};
    tbl[11] = '{IR_ADDI, 1'b0, mk(5, ZLO_OUT, 0, 16'h8000, 0, 0, 0)};

    clear = 1'b0; ir = 32'hFFFF_FFFF; mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_out("reset_outputs", '0);
    clear = 1'b1;

    for (int i = 0; i < 12; i++) apply(tbl[i], "table");

    ri_cnt = 0;
    build(IR_MUL, 0);
    check_eq("mul_len", q.size(), 7);
    run_q("mul", q.size());
    check_eq("mul_no_reg_in", ri_cnt, 0);

    t1_cnt = 0;
    build(IR_ADD, 3);
    run_q("wait3", q.size());
    check_eq("wait_t1_cycles", t1_cnt, 4);

    ill_cnt = 0;
    build(IR_ILL, 0);
    run_q("illegal", q.size());
    check_eq("illegal_pulses", ill_cnt, 1);

    ri_cnt = 0;
    build(IR_ADDI, 0);
    run_q("addi_pre_reset", 4);
    ir = IR_ADDI;
    #1;
    check_eq("addi_in_t4", step, 4);
    clear = 1'b0;
    #1;
    check_out("reset_mid_async", '0);
    @(posedge clock);
    #1;
    check_out("reset_mid_held", '0);
    clear = 1'b1;
    build(IR_NOP, 0);
    run_q("after_reset", q.size());
    check_eq("no_partial_writeback", ri_cnt, 0);

    begin
      int start = cyc;
      while (cyc - start < 10000) begin
        logic [31:0] r = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          if (r[31:27] == 5'd27) r[31:27] = 5'd31;
        end else begin
          r[31:27] = legal_ops[$urandom_range(0, 7)];
        end
        build(r, $urandom_range(0, 3));
        run_q("random", q.size());
      end
    end

    build(IR_HALT, 1);
    run_q("halt_fetch", q.size());
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v.ir = $urandom; v.mr = 1'($urandom); v.exp = mk(7, 0, 0, 0, 0, 1, 0);
      apply(v, "halted");
    end
    clear = 1'b0;
    #1;
    check_out("halt_reset", '0);
    @(posedge clock);
    #1;
    clear = 1'b1;
    build(IR_NOP, 0);
    run_q("post_halt", q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
